// File: rtl/core_shmem_arbiter.sv
// Two-master round-robin arbiter in front of a 1-cycle-latency single-port RAM.
// Optional stall counters are enabled with `define CORE_SHMEM_ARB_STATS_EN.
module core_shmem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef CORE_SHMEM_ARB_STATS_EN
  ,
  input  logic              stats_clear,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1
`endif
);

  logic [1:0] req, wr, gnt, stall;
  logic       rd_go;
  logic       last_grant_q, rd_pend_q, rd_owner_q;

  assign req = {m1_read | m1_write, m0_read | m0_write};
  assign wr  = {m1_write, m0_write};

  // On conflict the port that did not win last time is granted; nothing is granted in reset.
  assign gnt[0] = ~reset & req[0] & (~req[1] | last_grant_q);
  assign gnt[1] = ~reset & req[1] & (~req[0] | ~last_grant_q);
  assign stall  = req & ~gnt;
  assign rd_go  = |(gnt & ~wr);

  assign m0_waitrequest = stall[0];
  assign m1_waitrequest = stall[1];

  assign mem_address    = gnt[1] ? m1_address    : m0_address;
  assign mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
  assign mem_chipselect = |gnt;
  assign mem_write      = |(gnt & wr);
  assign mem_clken      = 1'b1;

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  // Gating with reset kills a response whose read was granted just before reset.
  assign m0_readdatavalid = rd_pend_q & ~reset & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & ~reset &  rd_owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      if (|gnt) last_grant_q <= gnt[1];
      rd_pend_q  <= rd_go;
      rd_owner_q <= gnt[1];
    end
  end

`ifdef CORE_SHMEM_ARB_STATS_EN
  logic [1:0][31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (stall[i] && stall_cnt_q[i] != 32'hFFFF_FFFF) stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
    end
  end

  assign stall_cnt0 = stall_cnt_q[0];
  assign stall_cnt1 = stall_cnt_q[1];
`endif

endmodule

// File: tb/tb_core_shmem_arbiter.sv
// Random + directed bench for core_shmem_arbiter: per-cycle grant model plus
// a read-response scoreboard drained by an independent monitor.
module tb_core_shmem_arbiter;
  localparam int AW = 13, DW = 32, BW = 4;

  typedef struct {
    bit           rd, wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
  } txn_t;
  typedef struct {
    int           due;
    int           port;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
`ifdef CORE_SHMEM_ARB_STATS_EN
  logic stats_clear = 1'b0;
  logic [31:0] stall_cnt0, stall_cnt1;
  logic [31:0] sc0 = 0, sc1 = 0;
`endif

  core_shmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef CORE_SHMEM_ARB_STATS_EN
    , .stats_clear(stats_clear), .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // RAM: registered address, unregistered data out.
  logic [DW-1:0] ram [8192];
  logic [AW-1:0] ram_aq = '0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_aq <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_aq];

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [int];
  int   lg = 1;          // last granted port
  int   gr;              // port granted in the most recent step, -1 if none
  rsp_t sb[$];
  txn_t cur[2];
  txn_t IDLE;
  bit   pw0 = 0, pw1 = 0;

  function automatic txn_t mk(bit rd, bit wr, int a, logic [BW-1:0] be, logic [DW-1:0] d);
    txn_t t;
    t.rd = rd; t.wr = wr; t.a = AW'(a); t.be = be; t.d = d;
    return t;
  endfunction

  function automatic txn_t rnd();
    int k = $urandom_range(0, 2);
    return mk(k != 1, k != 0, $urandom_range(0, 15), BW'($urandom), $urandom);
  endfunction

  function automatic bit busy(int p);
    return cur[p].rd | cur[p].wr;
  endfunction

  task automatic apply();
    m0_address = cur[0].a; m0_byteenable = cur[0].be; m0_read = cur[0].rd;
    m0_write = cur[0].wr; m0_writedata = cur[0].d;
    m1_address = cur[1].a; m1_byteenable = cur[1].be; m1_read = cur[1].rd;
    m1_write = cur[1].wr; m1_writedata = cur[1].d;
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance the model.
  task automatic step();
    bit r0, r1;
    int g;
    logic [DW-1:0] m;
    txn_t t;
    apply();
    @(negedge clk);
    r0 = busy(0); r1 = busy(1);
    if (reset)         g = -1;
    else if (r0 && r1) g = 1 - lg;
    else if (r0)       g = 0;
    else if (r1)       g = 1;
    else               g = -1;
    chk("wait0", m0_waitrequest, r0 && g != 0);
    chk("wait1", m1_waitrequest, r1 && g != 1);
    chk("wait0_twice", m0_waitrequest & pw0, 0);
    chk("wait1_twice", m1_waitrequest & pw1, 0);
    pw0 = m0_waitrequest; pw1 = m1_waitrequest;
    chk("chipselect", mem_chipselect, g >= 0);
    chk("clken", mem_clken, 1);
    if (g >= 0) begin
      t = cur[g];
      chk("mem_address", mem_address, t.a);
      chk("mem_write", mem_write, t.wr);
      if (t.wr) begin
        chk("mem_be", mem_byteenable, t.be);
        chk("mem_wdata", mem_writedata, t.d);
        m = {{8{t.be[3]}}, {8{t.be[2]}}, {8{t.be[1]}}, {8{t.be[0]}}};
        ref_mem[int'(t.a)] = (ref_mem.exists(int'(t.a)) ? ref_mem[int'(t.a)] & ~m : '0) | (t.d & m);
      end else begin
        sb.push_back('{cyc + 1, g, ref_mem[int'(t.a)]});
      end
      lg = g;
    end else begin
      chk("idle_address", mem_address, m0_address);
      chk("idle_write", mem_write, 0);
    end
`ifdef CORE_SHMEM_ARB_STATS_EN
    chk("stall_cnt0", stall_cnt0, sc0);
    chk("stall_cnt1", stall_cnt1, sc1);
    if (reset || stats_clear) begin sc0 = 0; sc1 = 0; end
    else begin
      if (r0 && g != 0 && sc0 != 32'hFFFF_FFFF) sc0++;
      if (r1 && g != 1 && sc1 != 32'hFFFF_FFFF) sc1++;
    end
`endif
    if (reset) lg = 1;
    gr = g;
    @(posedge clk); #1;
  endtask

  task automatic run_pending();
    int n = 0;
    while ((busy(0) || busy(1)) && n < 8) begin
      step();
      if (gr >= 0) cur[gr] = IDLE;
      n++;
    end
    checks++;
    if (busy(0) || busy(1)) begin
      errors++;
      $display("FAIL grant_timeout: requests still pending after %0d cycles", n);
      cur[0] = IDLE; cur[1] = IDLE;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  // Monitor: a response is due exactly one cycle after its read was granted.
  always @(negedge clk) begin
    rsp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (reset) begin
        chk("rdv_in_reset", {m1_readdatavalid, m0_readdatavalid}, 0);
      end else begin
        chk("rdv_port", {m1_readdatavalid, m0_readdatavalid}, (e.port == 1) ? 2'b10 : 2'b01);
        chk("rdata", (e.port == 1) ? m1_readdata : m0_readdata, e.data);
      end
    end else begin
      chk("rdv_idle", {m1_readdatavalid, m0_readdatavalid}, 0);
    end
  end

  initial begin
    IDLE = mk(0, 0, 0, 0, 0);
    cur[0] = IDLE; cur[1] = IDLE;
    apply();
    reset_pulse();
    // Fill the address range used by random traffic.
    for (int a = 0; a < 16; a++) begin
      cur[0] = mk(0, 1, a, 4'hF, 32'h0101_0101 * a); run_pending();
    end
    // m0 write then read back
    cur[0] = mk(0, 1, 'h10, 4'hF, 32'hDEAD_BEEF); run_pending();
    cur[0] = mk(1, 0, 'h10, 4'hF, 0);             run_pending();
    // simultaneous reads right after reset: m0 first
    reset_pulse();
    cur[0] = mk(1, 0, 'h1, 4'hF, 0); cur[1] = mk(1, 0, 'h2, 4'hF, 0); run_pending();
    // continuous contention
    cur[0] = mk(1, 0, 3, 4'hF, 0); cur[1] = mk(1, 0, 4, 4'hF, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (gr >= 0) cur[gr] = mk(1, 0, $urandom_range(0, 15), 4'hF, 0);
    end
    run_pending();
    // partial byte write from m1
    cur[1] = mk(0, 1, 5, 4'hF, 32'hFFFF_FFFF); run_pending();
    cur[1] = mk(0, 1, 5, 4'h3, 32'h1234_5678); run_pending();
    cur[1] = mk(1, 0, 5, 4'hF, 0);             run_pending();
    // read+write together counts as a write
    cur[0] = mk(1, 1, 'h20, 4'hF, 32'hA5A5_A5A5); run_pending();
    cur[0] = mk(1, 0, 'h20, 4'hF, 0);             run_pending();
    // reset right after a read grant drops the response
    cur[0] = mk(1, 0, 'h10, 4'hF, 0); step(); cur[0] = IDLE;
    reset = 1'b1; step(); reset = 1'b0; step();
`ifdef CORE_SHMEM_ARB_STATS_EN
    reset_pulse();
    cur[0] = mk(1, 0, 1, 4'hF, 0); cur[1] = mk(1, 0, 2, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (gr >= 0) cur[gr] = mk(1, 0, $urandom_range(0, 15), 4'hF, 0);
    end
    run_pending();
    step();
    stats_clear = 1'b1; step(); stats_clear = 1'b0; step();
`endif
    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!busy(p) && $urandom_range(0, 9) < 7) cur[p] = rnd();
      step();
      if (gr >= 0) cur[gr] = IDLE;
    end
    run_pending();
    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses never arrived, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
